alu_exec_stage: RTL
===================

Name: alu_exec_stage

Overview:
- Execute-stage ALU that consumes the 3-bit alu_operation code produced by the ALU control decoder and carries out the operation on two operands.
- Sits between the decode/operand-fetch stage and writeback.
- Valid/ready handshake on both sides.
- Results are buffered in a 2-entry output queue, so a writeback stall does not drop work and in_ready is driven only by registered state.

Parameters:
- XLEN, 32, operand and result width in bits.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all queued results and the current input
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  stage can accept an operation this cycle
- alu_operation  input  3  operation code (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 decoder default, 7 ALU disabled)
- operand_a  input  XLEN  first operand
- operand_b  input  XLEN  second operand
- rd_addr  input  5  destination register tag, passed through unchanged
- out_valid  output  1  head result is valid
- out_ready  input  1  downstream accepts the head result
- result  output  XLEN  head result value
- zero  output  1  head result equals 0
- illegal  output  1  head entry came from an unsupported code
- out_rd_addr  output  5  head destination tag
- op_count  output  CNT_W  number of legal results retired

Behaviour:
- Reset (rst=1 at a clk edge):
  - Queue count becomes 0 and op_count becomes 0.
  - out_valid=0, in_ready=1.
  - result, zero, illegal and out_rd_addr read 0 while the queue is empty.
  - Reset wins over every other input in the same cycle.
- Queue:
  - 2 entries, each holding {result, zero, illegal, rd_addr}.
  - State is count ∈ {EMPTY=0, ONE=1, FULL=2}, plus a 1-bit read pointer.
- Output decoding:
  - in_ready = (count != FULL), decoded from registered state only.
  - out_valid = (count != EMPTY).
  - Head outputs are read directly from the entry at the read pointer.
- Transfer rules:
  - Accept: in_valid && in_ready at the clk edge.
  - Pop: out_valid && out_ready at the clk edge.
- Codes 0–4 and 5/6:
  - An accepted operation is computed combinationally in the accept cycle and written to the tail.
  - Latency is 1 cycle: out_valid rises the cycle after accept when the queue was empty.
- Arithmetic:
  - add/sub are modulo 2^XLEN; carry and overflow are discarded.
  - 0x FFFFFFFF + 1 = 0 with zero=1.
  - and/or/xor are bitwise.
  - Example: 0 − 1 = 0xFFFFFFFF.
- Codes 5 and 6:
  - The entry is enqueued with result=0, zero=1, illegal=1.
  - op_count is not incremented when the entry is popped.
- Code 7 (ALU disabled):
  - Handshake completes (consumed), but nothing is enqueued and op_count is unchanged.
- Count transitions:
  - Accept without pop: count+1.
  - Pop without accept: count−1.
  - Accept and pop together (count=ONE): count stays ONE; the new entry becomes head next cycle.
  - Accept and pop together (count=EMPTY): impossible, since out_valid=0.
  - At FULL, in_ready=0, so only a pop can happen.
  - A code-7 accept concurrent with a pop counts as a pop only.
- Order: entries pop in acceptance order, strictly FIFO.
- op_count:
  - Increments by 1 on each pop of an entry with illegal=0.
  - Wraps from 2^CNT_W−1 to 0.
  - Not cleared by flush.
- Flush (rst=0):
  - Count becomes EMPTY, and any accept in the same cycle is discarded.
  - A pop in the same cycle still increments op_count if the head was legal (downstream already took it).
- Stability: head outputs must not change while out_valid=1 and out_ready=0.

Test Plan:
- Reset, then accept add with a=5, b=7, rd=3 and out_ready=1 → next cycle out_valid=1, result=12, zero=0, illegal=0, out_rd_addr=3; op_count=1 after the pop.
- Issue back-to-back: sub a=0 b=1, xor 0xA5A5A5A5^0xA5A5A5A5, or 0xF0^0x0F, with out_ready=1 → results 0xFFFFFFFF (zero=0), 0 (zero=1), 0xFF in order, one per cycle.
- Hold out_ready=0 and offer 3 ops → two accepted and in_ready=0 on the cycle after the second accept; head stays constant; after releasing out_ready, entries drain in order and the third op is accepted.
- Send codes 7, 5, 2 (a=0xC, b=0xA) → code 7 produces no output; code 5 gives result=0, illegal=1, zero=1; code 2 gives result=0x8; op_count ends at 1.
- With the queue FULL, assert flush together with out_ready=1 and in_valid=1 → next cycle out_valid=0, in_ready=1; op_count incremented once for the popped legal head; the offered op is never output.
- Preload op_count to 0xFFFF via 65535 legal retirements, then retire one more add → op_count=0x0000.
- Assert rst mid-stream with count=ONE → next cycle out_valid=0, in_ready=1, op_count=0.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_exec_stage_if : issue/writeback handshake bundle for alu_exec_stage    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
interface alu_exec_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_operation;
  logic [XLEN-1:0]  operand_a;
  logic [XLEN-1:0]  operand_b;
  logic [4:0]       rd_addr;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic             zero;
  logic             illegal;
  logic [4:0]       out_rd_addr;
  logic [CNT_W-1:0] op_count;

  // Upstream/downstream environment side.
  modport master (
    output flush, in_valid, alu_operation, operand_a, operand_b, rd_addr, out_ready,
    input  in_ready, out_valid, result, zero, illegal, out_rd_addr, op_count
  );

  // Execute stage side.
  modport slave (
    input  flush, in_valid, alu_operation, operand_a, operand_b, rd_addr, out_ready,
    output in_ready, out_valid, result, zero, illegal, out_rd_addr, op_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_exec_stage : execute-stage ALU with a 2-entry result queue             |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  alu_exec_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_e;

  count_e           count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [XLEN-1:0]  res_q  [2];
  logic             zero_q [2];
  logic             ill_q  [2];
  logic [4:0]       rd_q   [2];

  logic             in_ready_w;
  logic             out_valid_w;
  logic             accept_w;
  logic             pop_w;
  logic             enq_w;
  logic             wr_ptr_w;
  logic [XLEN-1:0]  alu_res_w;
  logic             alu_ill_w;

  assign in_ready_w  = (count_q != FULL);
  assign out_valid_w = (count_q != EMPTY);
  assign accept_w    = bus.in_valid && in_ready_w;
  assign pop_w       = out_valid_w && bus.out_ready;
  // Code 7 consumes the handshake without producing a queue entry.
  assign enq_w       = accept_w && (bus.alu_operation != 3'd7) && !bus.flush;
  assign wr_ptr_w    = rd_ptr_q ^ (count_q == ONE);

  always_comb begin
    alu_res_w = '0;
    alu_ill_w = 1'b0;
    case (bus.alu_operation)
      3'd0:    alu_res_w = bus.operand_a + bus.operand_b;
      3'd1:    alu_res_w = bus.operand_a - bus.operand_b;
      3'd2:    alu_res_w = bus.operand_a & bus.operand_b;
      3'd3:    alu_res_w = bus.operand_a | bus.operand_b;
      3'd4:    alu_res_w = bus.operand_a ^ bus.operand_b;
      default: alu_ill_w = 1'b1;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    op_count_d = op_count_q;
    // A popped head was taken downstream even when flush clears the queue.
    if (pop_w) begin
      rd_ptr_d = ~rd_ptr_q;
      if (!ill_q[rd_ptr_q]) begin
        op_count_d = op_count_q + CNT_W'(1);
      end
    end
    if (bus.flush) begin
      count_d = EMPTY;
    end else begin
      case ({enq_w, pop_w})
        2'b10:   count_d = (count_q == EMPTY) ? ONE : FULL;
        2'b01:   count_d = (count_q == FULL) ? ONE : EMPTY;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= EMPTY;
      rd_ptr_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      op_count_q <= op_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= '0;
        zero_q[i] <= 1'b0;
        ill_q[i]  <= 1'b0;
        rd_q[i]   <= '0;
      end
    end else if (enq_w) begin
      res_q[wr_ptr_w]  <= alu_res_w;
      zero_q[wr_ptr_w] <= (alu_res_w == '0);
      ill_q[wr_ptr_w]  <= alu_ill_w;
      rd_q[wr_ptr_w]   <= bus.rd_addr;
    end
  end

  // Head fields read as zero whenever the queue holds nothing.
  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_w;
  assign bus.result      = out_valid_w ? res_q[rd_ptr_q]  : '0;
  assign bus.zero        = out_valid_w ? zero_q[rd_ptr_q] : 1'b0;
  assign bus.illegal     = out_valid_w ? ill_q[rd_ptr_q]  : 1'b0;
  assign bus.out_rd_addr = out_valid_w ? rd_q[rd_ptr_q]   : 5'd0;
  assign bus.op_count    = op_count_q;

endmodule
`default_nettype wire
